// File: rtl/r2r_pkg.sv
// Shared types, constants and mV-to-code conversion for the R2R DAC driver.
// The SLEW state exists only when R2R_DAC_SLEW_EN is defined.
package r2r_pkg;

`ifdef R2R_DAC_SLEW_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_CONVERT,
        S_SLEW,
        S_SETTLE,
        S_DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_CONVERT,
        S_SETTLE,
        S_DONE
    } state_t;
`endif

    localparam int          CODE_WIDTH   = 8;
    localparam logic [7:0]  CODE_MAX     = 8'hFF;
    localparam logic [12:0] MV_TO_CODE_K = 13'd5066;

    // Returns {saturated, code}; 5066/65536 approximates 255 codes per 3300 mV
    function automatic logic [CODE_WIDTH:0] mv_to_code(input logic [15:0] mv);
        logic [28:0] prod;
        logic [12:0] q;
        prod = 29'(mv) * 29'(MV_TO_CODE_K);
        q    = 13'(prod >> 16);
        if (q > 13'd255)
            return {1'b1, CODE_MAX};
        return {1'b0, q[7:0]};
    endfunction

endpackage

// File: rtl/r2r_dac_driver_tick_gen.sv
// Slew tick strobe: one-cycle pulse every TICK_CYCLES clocks,
// restarted whenever clear is high.
module r2r_tick_gen #(
    parameter int TICK_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (clear || r_cnt == LAST)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

    assign tick = !clear && (r_cnt == LAST);

endmodule

// File: rtl/r2r_dac_driver.sv
// R2R ladder driver: converts a mV request to an 8-bit code and walks the bus to it.
// Define R2R_DAC_SLEW_EN to step one LSB per tick; otherwise the code loads directly.
module r2r_dac_driver
    import r2r_pkg::*;
#(
    parameter int TICK_CYCLES   = 1000,
    parameter int SETTLE_CYCLES = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] mv_in,
    input  logic        mv_valid,
    output logic        mv_ready,
    output logic [7:0]  r2r_bus,
    output logic [7:0]  target_code,
    output logic        busy,
    output logic        done,
    output logic        saturated
);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SLAST = SW'(SETTLE_CYCLES - 1);

    if (TICK_CYCLES < 1) begin : g_bad_tick
        $error("TICK_CYCLES must be at least 1");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("SETTLE_CYCLES must be at least 1");
    end

    state_t           r_state;
    logic [15:0]      r_mv;
    logic [7:0]       r_bus;
    logic [7:0]       r_target;
    logic             r_sat;
    logic             r_done;
    logic             r_busy;
    logic             r_ready;
    logic [SW-1:0]    r_settle;
    logic [8:0]       w_conv;

    assign w_conv = mv_to_code(r_mv);

`ifdef R2R_DAC_SLEW_EN
    logic       w_tick;
    logic [7:0] w_up;
    logic [7:0] w_dn;

    assign w_up = r_bus + 8'd1;
    assign w_dn = r_bus - 8'd1;

    r2r_tick_gen #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .clear(r_state != S_SLEW),
        .tick (w_tick)
    );
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_mv     <= '0;
            r_bus    <= '0;
            r_target <= '0;
            r_sat    <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_ready  <= 1'b1;
            r_settle <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mv_valid && r_ready) begin
                        r_mv    <= mv_in;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    r_target <= w_conv[7:0];
                    r_sat    <= w_conv[8];
                    r_settle <= '0;
`ifdef R2R_DAC_SLEW_EN
                    r_state  <= (w_conv[7:0] == r_bus) ? S_SETTLE : S_SLEW;
`else
                    r_bus    <= w_conv[7:0];
                    r_state  <= S_SETTLE;
`endif
                end
`ifdef R2R_DAC_SLEW_EN
                // Leave SLEW on the same edge that lands the final step
                S_SLEW: begin
                    if (r_bus == r_target) begin
                        r_state <= S_SETTLE;
                    end else if (w_tick) begin
                        if (r_bus < r_target) begin
                            r_bus <= w_up;
                            if (w_up == r_target)
                                r_state <= S_SETTLE;
                        end else begin
                            r_bus <= w_dn;
                            if (w_dn == r_target)
                                r_state <= S_SETTLE;
                        end
                    end
                end
`endif
                S_SETTLE: begin
                    if (r_settle == SLAST) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_settle <= r_settle + 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mv_ready    = r_ready;
    assign r2r_bus     = r_bus;
    assign target_code = r_target;
    assign busy        = r_busy;
    assign done        = r_done;
    assign saturated   = r_sat;

endmodule

// File: tb/tb_r2r_dac_driver.sv
// Directed bench for r2r_dac_driver, TICK_CYCLES=4, SETTLE_CYCLES=3.
// Expectations follow R2R_DAC_SLEW_EN as defined for the build.
module tb_r2r_dac_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] mv_in = '0;
    logic        mv_valid = 1'b0;
    logic        mv_ready;
    logic [7:0]  r2r_bus;
    logic [7:0]  target_code;
    logic        busy;
    logic        done;
    logic        saturated;

    int n_chk = 0;
    int n_err = 0;

    r2r_dac_driver #(
        .TICK_CYCLES  (4),
        .SETTLE_CYCLES(3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mv_in      (mv_in),
        .mv_valid   (mv_valid),
        .mv_ready   (mv_ready),
        .r2r_bus    (r2r_bus),
        .target_code(target_code),
        .busy       (busy),
        .done       (done),
        .saturated  (saturated)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Transfer-to-done latency for an N-step move
    function automatic int exp_lat(input int n);
`ifdef R2R_DAC_SLEW_EN
        return 1 + n * 4 + 3 + 1;
`else
        return 1 + 3 + 1 + 0 * n;
`endif
    endfunction

    // lat = clock edge (counted from the transfer edge) at which done is seen
    task automatic do_req(input logic [15:0] mv, output int lat,
                          output int bad);
        int         cnt;
        int         diff;
        logic       d;
        logic [7:0] prev;
        @(negedge clk);
        mv_in    = mv;
        mv_valid = 1'b1;
        prev     = r2r_bus;
        @(posedge clk);
        cnt = 0;
        lat = -1;
        bad = 0;
        while (cnt < 2000) begin
            @(negedge clk);
            mv_valid = 1'b0;
            d        = done;
            diff     = int'(r2r_bus) - int'(prev);
`ifdef R2R_DAC_SLEW_EN
            if (diff > 1 || diff < -1)
                bad++;
`endif
            prev = r2r_bus;
            @(posedge clk);
            cnt++;
            if (d) begin
                lat = cnt;
                break;
            end
        end
    endtask

    task automatic req_check(input string tag, input logic [15:0] mv,
                             input int steps, input int tgt,
                             input int sat);
        int lat;
        int bad;
        do_req(mv, lat, bad);
        #1;
        chk({tag, "_latency"}, lat, exp_lat(steps));
        chk({tag, "_target"}, target_code, tgt);
        chk({tag, "_sat"}, saturated, sat);
        chk({tag, "_bus"}, r2r_bus, tgt);
        chk({tag, "_step"}, bad, 0);
        chk({tag, "_ready"}, mv_ready, 1);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int wait_edges;
        int bus_exp;
        int dones;

        repeat (3) @(negedge clk);
        chk("rst_bus", r2r_bus, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_target", target_code, 0);
        chk("rst_sat", saturated, 0);
        chk("rst_ready", mv_ready, 1);

        req_check("mv1000", 16'd1000, 77, 77, 0);
        req_check("mv65535", 16'd65535, 178, 255, 1);
        req_check("mv1650", 16'd1650, 128, 127, 0);
        req_check("mv1650_again", 16'd1650, 0, 127, 0);
        req_check("mv0", 16'd0, 127, 0, 0);

`ifdef R2R_DAC_SLEW_EN
        wait_edges = 20;
        bus_exp    = 4;
`else
        wait_edges = 3;
        bus_exp    = 77;
`endif
        @(negedge clk);
        mv_in    = 16'd1000;
        mv_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mv_valid = 1'b0;
        chk("busy_ready", mv_ready, 0);
        @(posedge clk);
        @(negedge clk);
        mv_in    = 16'd65535;
        mv_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mv_valid = 1'b0;
        repeat (wait_edges - 2) @(posedge clk);
        #1;
        chk("ignored_target", target_code, 77);
        chk("ignored_sat", saturated, 0);
        chk("midop_busy", busy, 1);
        chk("midop_bus", r2r_bus, bus_exp);

        reset = 1'b1;
        #1;
        chk("abort_bus", r2r_bus, 0);
        chk("abort_target", target_code, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_ready", mv_ready, 1);
        dones = 0;
        repeat (400) begin
            @(negedge clk);
            if (done)
                dones++;
        end
        chk("abort_no_done", dones, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/r2r_dac_driver.md
R2R_DAC_DRIVER -- requirements
Module: r2r_dac_driver

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 1000: clk cycles per slew step (minimum 1).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 100: clk cycles held after the final code before done (minimum 1).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port mv_in  input  16  requested output voltage in millivolts, unsigned.
REQ-006 SHALL have port mv_valid  input  1  request qualifier.
REQ-007 SHALL have port mv_ready  output  1  high only in IDLE; a transfer occurs when mv_valid and mv_ready are both high at a clk edge.
REQ-008 SHALL have port r2r_bus  output  8  registered code driving the R2R ladder.
REQ-009 SHALL have port target_code  output  8  registered converted code of the last accepted request.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port done  output  1  single-cycle pulse when r2r_bus has settled at target_code.
REQ-012 SHALL have port saturated  output  1  registered; high when the last accepted request exceeded full scale.

Function
REQ-013 SHALL implement the states IDLE, CONVERT, SLEW, SETTLE and DONE.
REQ-014 IDLE SHALL go to CONVERT on a transfer, latching mv_in; mv_valid is ignored in every other state, with no queueing.
REQ-015 CONVERT SHALL last one cycle and compute prod = mv_in * 5066 (29-bit unsigned); code = prod[23:16] when prod[28:16] <= 255, else code = 255 and saturated = 1; otherwise saturated = 0.
REQ-016 target_code and saturated SHALL update at the end of CONVERT and hold until the next CONVERT.
REQ-017 SLEW SHALL move r2r_bus by exactly one LSB toward target_code on each tick; a tick is a one-cycle strobe every TICK_CYCLES clks, and its counter restarts on entry to SLEW.
REQ-018 SLEW SHALL go to SETTLE in the cycle in which r2r_bus equals target_code, including on entry when they are already equal (zero steps).
REQ-019 SETTLE SHALL count SETTLE_CYCLES clks, then go to DONE.
REQ-020 DONE SHALL assert done for exactly one cycle, then return to IDLE, where mv_ready is high on the next cycle.
REQ-021 r2r_bus SHALL never wrap: a step never goes below 0 or above 255.
REQ-022 Latency from transfer to done SHALL be 1 + N*TICK_CYCLES + SETTLE_CYCLES + 1 cycles with slew enabled, where N = |target - start|; with slew disabled it SHALL be 1 + SETTLE_CYCLES + 1.

Reset
REQ-023 Reset SHALL force state IDLE and r2r_bus = 0, target_code = 0, saturated = 0, done = 0, busy = 0, and clear all counters; mv_ready SHALL be high after release.
REQ-024 Reset asserted mid-operation SHALL abort immediately with no done pulse.

Configuration
REQ-025 With R2R_DAC_SLEW_EN defined, SHALL slew as in REQ-017.
REQ-026 Without R2R_DAC_SLEW_EN, CONVERT SHALL load r2r_bus = code directly and go to SETTLE; the SLEW state and the tick logic SHALL be absent.

Structure
REQ-027 Package r2r_pkg SHALL hold the state enum, MV_TO_CODE_K = 5066, CODE_MAX = 8'hFF and CODE_WIDTH = 8.
REQ-028 The tick strobe SHALL be a sub-module, r2r_tick_gen (ports clk, reset, clear, tick), instantiated only under R2R_DAC_SLEW_EN.

Verification (TICK_CYCLES = 4, SETTLE_CYCLES = 3)
REQ-029 Reset, then mv_in = 1000 with valid -> target_code = 77, saturated = 0, r2r_bus steps 0..77 one step per 4 clks, done pulse at cycle 1 + 308 + 3 + 1 = 313 after the transfer.
REQ-030 mv_in = 65535 -> target_code = 255, saturated = 1, r2r_bus stops at 255 with no wrap.
REQ-031 From r2r_bus = 127 (mv_in = 1650), request mv_in = 0 -> bus decrements to 0, done pulses, saturated = 0.
REQ-032 Repeat mv_in = 1650 while at 127 -> zero steps, done exactly 5 cycles after the transfer.
REQ-033 mv_valid pulsed while busy -> no transfer, target_code unchanged; reset mid-SLEW -> r2r_bus = 0 at once, no done, mv_ready high after release.
REQ-034 Build without R2R_DAC_SLEW_EN, mv_in = 1000 -> r2r_bus = 77 after CONVERT, done 5 cycles after the transfer.
